// File: rtl/seg7_count_ctrl_pkg.sv
// Shared definitions for the counter display: FSM encodings, segment constants
// and the BCD step function used by the count tick.
package seg7_count_ctrl_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Ripple +/-1 through four BCD digits; out-of-range digits are forced back into 0..9.
    function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic up);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c) begin
                if (up) begin
                    if (v[4*i +: 4] >= 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (v[4*i +: 4] == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                    end else if (v[4*i +: 4] > 4'd9) begin
                        r[4*i +: 4] = 4'd8;
                        c = 1'b0;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}; non-decimal codes blank.
module seg7_decode
    import seg7_count_ctrl_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'h40;
            4'd1: seg = 7'h79;
            4'd2: seg = 7'h24;
            4'd3: seg = 7'h30;
            4'd4: seg = 7'h19;
            4'd5: seg = 7'h12;
            4'd6: seg = 7'h02;
            4'd7: seg = 7'h78;
            4'd8: seg = 7'h00;
            4'd9: seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_count_ctrl.sv
// 4-digit BCD counter with start/stop/clear control and a multiplexed
// active-low 7-segment display driver.
module seg7_count_ctrl
    import seg7_count_ctrl_pkg::*;
#(
    parameter int CNT_DIV  = 250000000,
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clr,
    input  logic        up_dn,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        running,
    output logic [15:0] value
);

    localparam int CW = $clog2(CNT_DIV);
    localparam int SW = $clog2(SCAN_DIV);

    logic [1:0]    state, state_nx;
    logic [CW-1:0] cdiv;
    logic [SW-1:0] sdiv;
    logic [1:0]    idx;
    logic          advance, tick;
    logic [3:0]    digit;
    logic [6:0]    seg_dec;
    logic          blank;

    always_comb begin
        state_nx = state;
        if (clr)
            state_nx = ST_IDLE;
        else if (start && state != ST_RUN)
            state_nx = ST_RUN;
        else if (stop && state == ST_RUN)
            state_nx = ST_HOLD;
    end

    // The divider only moves while staying in RUN, so a stop or clear edge never ticks
    // and a resume continues from the paused phase.
    assign advance = (state == ST_RUN) && (state_nx == ST_RUN);
    assign tick    = advance && (cdiv == CW'(CNT_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            cdiv    <= '0;
            value   <= '0;
        end else begin
            state   <= state_nx;
            running <= (state_nx == ST_RUN);
            if (clr)
                cdiv <= '0;
            else if (advance)
                cdiv <= tick ? '0 : cdiv + 1'b1;
            if (clr)
                value <= '0;
            else if (tick)
                value <= bcd_step(value, up_dn);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdiv <= '0;
            idx  <= '0;
        end else if (sdiv == SW'(SCAN_DIV - 1)) begin
            sdiv <= '0;
            idx  <= idx + 2'd1;
        end else begin
            sdiv <= sdiv + 1'b1;
        end
    end

    always_comb begin
        digit = value[3:0];
        blank = 1'b0;
        case (idx)
            2'd1: begin digit = value[7:4];   blank = (value[15:4]  == '0); end
            2'd2: begin digit = value[11:8];  blank = (value[15:8]  == '0); end
            2'd3: begin digit = value[15:12]; blank = (value[15:12] == '0); end
            default: begin digit = value[3:0]; blank = 1'b0; end
        endcase
    end

    seg7_decode u_dec (
        .bcd (digit),
        .seg (seg_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'hF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= (BLANK_LZ && blank) ? SEG_BLANK : seg_dec;
            dp  <= ~((idx == 2'd0) && (state == ST_HOLD));
        end
    end

endmodule

// File: tb/tb_seg7_count_ctrl.sv
// Directed bench for seg7_count_ctrl with short dividers; a second instance covers blanking.
module tb_seg7_count_ctrl;

    logic        clk, rst, start, stop, clr, up_dn;
    logic [3:0]  an, an_b;
    logic [6:0]  seg, seg_b;
    logic        dp, dp_b, running, running_b;
    logic [15:0] value, value_b;
    int          n_cmp, n_err;

    seg7_count_ctrl #(.CNT_DIV(10), .SCAN_DIV(4), .BLANK_LZ(1'b0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .up_dn(up_dn),
        .an(an), .seg(seg), .dp(dp), .running(running), .value(value)
    );

    seg7_count_ctrl #(.CNT_DIV(10), .SCAN_DIV(4), .BLANK_LZ(1'b1)) u_blz (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .up_dn(up_dn),
        .an(an_b), .seg(seg_b), .dp(dp_b), .running(running_b), .value(value_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; the pulse is sampled by the following posedge.
    task automatic drive(input logic s, input logic p, input logic c);
        start = s; stop = p; clr = c;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; clr = 1'b0;
    endtask

    task automatic chk_val(input string name, input logic [15:0] exp);
        n_cmp++;
        if (value !== exp) begin
            n_err++;
            $display("FAIL %s: value=%h expected %h", name, value, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0; up_dn = 1'b1;
        #2;
        n_cmp++;
        if ({an, seg, dp, running, value} !== {4'hF, 7'h7F, 1'b1, 1'b0, 16'h0000}) begin
            n_err++;
            $display("FAIL reset: an=%h seg=%h dp=%b run=%b val=%h expected F 7f 1 0 0000",
                     an, seg, dp, running, value);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle();
        logic [3:0] pat [4];
        pat = '{4'hE, 4'hD, 4'hB, 4'h7};
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            n_cmp++;
            if (an !== pat[j/4]) begin
                n_err++;
                $display("FAIL scan_rot[%0d]: an=%h expected %h", j, an, pat[j/4]);
            end
        end
        for (int j = 0; j < 84; j++) begin
            @(negedge clk);
            n_cmp++;
            if (value !== 16'h0 || running !== 1'b0) begin
                n_err++;
                $display("FAIL idle[%0d]: value=%h running=%b expected 0000 0", j, value, running);
            end
        end
    endtask

    task automatic test_count();
        up_dn = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (running !== 1'b1) begin
            n_err++;
            $display("FAIL run_flag: running=%b expected 1", running);
        end
        repeat (9) @(negedge clk);
        chk_val("cnt_pre_tick", 16'h0000);
        @(negedge clk);
        chk_val("cnt_1", 16'h0001);
        repeat (10) @(negedge clk);
        chk_val("cnt_2", 16'h0002);
    endtask

    task automatic test_stop_resume();
        drive(1'b0, 1'b0, 1'b1);
        chk_val("clr", 16'h0000);
        drive(1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        drive(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (running !== 1'b0) begin
            n_err++;
            $display("FAIL hold_flag: running=%b expected 0", running);
        end
        repeat (34) @(negedge clk);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            n_cmp++;
            if (dp !== (an == 4'hE ? 1'b0 : 1'b1)) begin
                n_err++;
                $display("FAIL hold_dp[%0d]: dp=%b an=%h expected dp %b", j, dp, an, an != 4'hE);
            end
        end
        chk_val("hold_value", 16'h0000);
        drive(1'b1, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        chk_val("resume_pre", 16'h0000);
        @(negedge clk);
        chk_val("resume_tick", 16'h0001);
        n_cmp++;
        if (dp !== 1'b1) begin
            n_err++;
            $display("FAIL run_dp: dp=%b expected 1", dp);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 1'b1);
        up_dn = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        chk_val("down_wrap", 16'h9999);
        up_dn = 1'b1;
        repeat (10) @(negedge clk);
        chk_val("up_wrap", 16'h0000);
        up_dn = 1'b0;
        repeat (10) @(negedge clk);
        chk_val("down_wrap2", 16'h9999);
    endtask

    task automatic test_carry();
        drive(1'b0, 1'b0, 1'b1);
        up_dn = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        repeat (9900) @(negedge clk);
        chk_val("reach_0990", 16'h0990);
        repeat (10) @(negedge clk);
        chk_val("carry_0991", 16'h0991);
        repeat (80) @(negedge clk);
        chk_val("reach_0999", 16'h0999);
        repeat (10) @(negedge clk);
        chk_val("carry_1000", 16'h1000);
        up_dn = 1'b0;
        repeat (10) @(negedge clk);
        chk_val("borrow_0999", 16'h0999);
    endtask

    task automatic test_priority();
        drive(1'b0, 1'b0, 1'b1);
        up_dn = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        repeat (420) @(negedge clk);
        chk_val("reach_0042", 16'h0042);
        drive(1'b1, 1'b1, 1'b1);
        chk_val("all_cmd_val", 16'h0000);
        n_cmp++;
        if (running !== 1'b0) begin
            n_err++;
            $display("FAIL all_cmd_run: running=%b expected 0", running);
        end
        drive(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (running !== 1'b1) begin
            n_err++;
            $display("FAIL start_stop_idle: running=%b expected 1", running);
        end
    endtask

    task automatic test_blank();
        drive(1'b0, 1'b0, 1'b1);
        up_dn = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        repeat (70) @(negedge clk);
        chk_val("reach_0007", 16'h0007);
        drive(1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            n_cmp++;
            if (seg_b !== (an_b == 4'hE ? 7'h78 : 7'h7F)) begin
                n_err++;
                $display("FAIL blank_lz[%0d]: seg=%h an=%h expected %h", j, seg_b, an_b,
                         an_b == 4'hE ? 7'h78 : 7'h7F);
            end
            n_cmp++;
            if (seg !== (an == 4'hE ? 7'h78 : 7'h40)) begin
                n_err++;
                $display("FAIL no_blank[%0d]: seg=%h an=%h expected %h", j, seg, an,
                         an == 4'hE ? 7'h78 : 7'h40);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        chk_val("pre_reset", 16'h0001);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({an, seg, dp, running, value} !== {4'hF, 7'h7F, 1'b1, 1'b0, 16'h0000}) begin
            n_err++;
            $display("FAIL async_rst: an=%h seg=%h dp=%b run=%b val=%h expected F 7f 1 0 0000",
                     an, seg, dp, running, value);
        end
        n_cmp++;
        if ({an_b, seg_b, running_b, value_b} !== {4'hF, 7'h7F, 1'b0, 16'h0000}) begin
            n_err++;
            $display("FAIL async_rst_b: an=%h seg=%h run=%b val=%h expected F 7f 0 0000",
                     an_b, seg_b, running_b, value_b);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk_val("post_reset", 16'h0000);
        n_cmp++;
        if (running !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_run: running=%b expected 0", running);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_idle();
        test_count();
        test_stop_resume();
        test_wrap();
        test_carry();
        test_priority();
        test_blank();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
